// File: rtl/pwm_audio_sample_pacer.sv
// Sample pacer feeding pwm_audio_stereo_out.
// Buffers stereo PCM pairs, releases one pair per sample period and presents
// the pair as registered 8-bit offset-binary duty values. When the producer
// falls behind, an underrun is flagged and counted.
module pwm_audio_sample_pacer #(
  parameter int unsigned IN_W            = 16,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned CLKS_PER_SAMPLE = 256,
  parameter bit          UNDERRUN_MID    = 1'b1
) (
  input  logic                     clk,
  input  logic                     aclr,
  input  logic                     enable,
  input  logic [IN_W-1:0]          in_left,
  input  logic [IN_W-1:0]          in_right,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               left_top,
  output logic [7:0]               right_top,
  output logic                     sample_tick,
  output logic                     underrun,
  output logic [15:0]              underrun_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;

  localparam logic [CW-1:0] CntLast   = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);
  localparam logic [7:0]    Midscale  = 8'h80;
  localparam logic [15:0]   CountMax  = 16'hFFFF;

  // Only the top 8 bits of each sample reach the PWM stage, so the FIFO holds
  // the already-converted bytes; the discarded LSBs are truncated, not rounded.
  function automatic logic [7:0] to_offset8(input logic [7:0] msbs);
    return {~msbs[7], msbs[6:0]};
  endfunction

  if (IN_W > 8) begin : g_drop_lsbs
    logic unused_lsbs;
    assign unused_lsbs = ^{in_left[IN_W-9:0], in_right[IN_W-9:0]};
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q,  level_d;
  logic [CW-1:0] cnt_q;
  logic [7:0]    left_q,   right_q;
  logic          underrun_q;
  logic [15:0]   ucount_q;

  logic          push, pop, starve, tick;
  logic [15:0]   push_data;
  logic [15:0]   head;

  // Handshake, tick and pop/underrun decisions, all from registered state.
  always_comb begin
    in_ready  = (level_q != LevelFull);
    push      = in_valid && in_ready;
    tick      = enable && (cnt_q == CntLast);
    pop       = tick && (level_q != '0);
    // A push landing in the same cycle is not bypassed: empty at tick is an
    // underrun and the new pair stays queued for the next period.
    starve    = tick && (level_q == '0);
    push_data = {to_offset8(in_left[IN_W-1 -: 8]), to_offset8(in_right[IN_W-1 -: 8])};
    head      = mem_q[rd_ptr_q];
  end

  // Occupancy next-state: simultaneous push and pop leaves level unchanged.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !aclr) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // FIFO pointers and occupancy; depth is a power of two so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (aclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Sample-period divider; frozen while enable is low.
  always_ff @(posedge clk) begin
    if (aclr) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + CW'(1);
    end
  end

  // Duty outputs change only at the edge ending a tick, so they stay stable
  // for a whole PWM frame.
  always_ff @(posedge clk) begin
    if (aclr) begin
      left_q  <= Midscale;
      right_q <= Midscale;
    end else if (pop) begin
      left_q  <= head[15:8];
      right_q <= head[7:0];
    end else if (starve && UNDERRUN_MID) begin
      left_q  <= Midscale;
      right_q <= Midscale;
    end
  end

  // Underrun pulse and saturating counter.
  always_ff @(posedge clk) begin
    if (aclr) begin
      underrun_q <= 1'b0;
      ucount_q   <= '0;
    end else begin
      underrun_q <= starve;
      if (starve && (ucount_q != CountMax)) begin
        ucount_q <= ucount_q + 16'd1;
      end
    end
  end

  assign left_top       = left_q;
  assign right_top      = right_q;
  assign sample_tick    = tick;
  assign underrun       = underrun_q;
  assign underrun_count = ucount_q;
  assign level          = level_q;

endmodule

// File: tb/tb_pwm_audio_sample_pacer.sv
// Randomized bench for pwm_audio_sample_pacer against a queue-based model.
// Two instances share stimulus: midscale-on-underrun and hold-on-underrun.
module tb_pwm_audio_sample_pacer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CPS   = 256;

  logic        clk = 1'b0;
  logic        aclr, enable, in_valid;
  logic [15:0] in_left, in_right;

  logic        in_ready, sample_tick, underrun;
  logic [7:0]  left_top, right_top;
  logic [15:0] underrun_count;
  logic [3:0]  level;

  logic        in_ready_h, sample_tick_h, underrun_h;
  logic [7:0]  left_top_h, right_top_h;
  logic [15:0] underrun_count_h;
  logic [3:0]  level_h;

  pwm_audio_sample_pacer #(
    .IN_W(16), .DEPTH(DEPTH), .CLKS_PER_SAMPLE(CPS), .UNDERRUN_MID(1'b1)
  ) dut (
    .clk(clk), .aclr(aclr), .enable(enable), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready), .left_top(left_top), .right_top(right_top),
    .sample_tick(sample_tick), .underrun(underrun), .underrun_count(underrun_count),
    .level(level)
  );

  pwm_audio_sample_pacer #(
    .IN_W(16), .DEPTH(DEPTH), .CLKS_PER_SAMPLE(CPS), .UNDERRUN_MID(1'b0)
  ) dut_hold (
    .clk(clk), .aclr(aclr), .enable(enable), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready_h), .left_top(left_top_h),
    .right_top(right_top_h), .sample_tick(sample_tick_h), .underrun(underrun_h),
    .underrun_count(underrun_count_h), .level(level_h)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit          m_ok = 1'b0;
  int          m_cnt;
  logic [31:0] m_q[$];
  int          m_l, m_r, m_hl, m_hr, m_und, m_uc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Offset-binary byte as plain arithmetic: shift the signed range up, keep top 8 bits.
  function automatic int conv(input logic [15:0] s);
    return (int'($signed(s)) + 32768) / 256;
  endfunction

  task automatic cyc(input bit clr, input bit en, input bit v,
                     input logic [15:0] l, input logic [15:0] r);
    bit          tick, acc;
    logic [31:0] p;
    aclr = clr; enable = en; in_valid = v; in_left = l; in_right = r;
    #1;
    if (m_ok) begin
      check_eq("level", level, m_q.size());
      check_eq("in_ready", in_ready, m_q.size() < DEPTH);
      check_eq("level_hold", level_h, m_q.size());
      if (!clr) check_eq("sample_tick", sample_tick, en && (m_cnt == CPS - 1));
    end
    if (clr) begin
      m_q.delete();
      m_cnt = 0; m_l = 128; m_r = 128; m_hl = 128; m_hr = 128; m_und = 0; m_uc = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      tick  = en && (m_cnt == CPS - 1);
      acc   = v && (m_q.size() < DEPTH);
      m_und = 0;
      if (tick) begin
        if (m_q.size() > 0) begin
          p = m_q.pop_front();
          m_l = conv(p[31:16]); m_r = conv(p[15:0]); m_hl = m_l; m_hr = m_r;
        end else begin
          m_und = 1;
          if (m_uc < 65535) m_uc++;
          m_l = 128; m_r = 128;
        end
      end
      if (acc) m_q.push_back({l, r});
      if (en) m_cnt = (m_cnt + 1) % CPS;
    end
    @(posedge clk);
    #1;
    if (m_ok) begin
      check_eq("left_top", left_top, m_l);
      check_eq("right_top", right_top, m_r);
      check_eq("left_top_hold", left_top_h, m_hl);
      check_eq("right_top_hold", right_top_h, m_hr);
      check_eq("underrun", underrun, m_und);
      check_eq("underrun_count", underrun_count, m_uc);
      check_eq("underrun_count_hold", underrun_count_h, m_uc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    // Reset held two cycles, then explicit reset-state checks.
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    check_eq("rst_left", left_top, 8'h80);
    check_eq("rst_right", right_top, 8'h80);
    check_eq("rst_level", level, 4'd0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_ucount", underrun_count, 16'd0);

    // Conversion extremes and zero / minus one.
    cyc(1'b0, 1'b0, 1'b1, 16'h8000, 16'h7FFF);
    cyc(1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF);
    idle(CPS);
    check_eq("conv_left_min", left_top, 8'h00);
    check_eq("conv_right_max", right_top, 8'hFF);
    idle(CPS);
    check_eq("conv_left_zero", left_top, 8'h80);
    check_eq("conv_right_m1", right_top, 8'h7F);

    // Fill with divider frozen: nine offered, eight accepted.
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b1, 16'($urandom), 16'($urandom));
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    check_eq("full_level", level, 4'd8);
    check_eq("full_ready", in_ready, 1'b0);

    // Drain, then several empty periods of underruns.
    idle(9 * CPS + 3 * CPS);

    // Push exactly in a tick cycle with an empty FIFO.
    while (m_cnt != CPS - 1) idle(1);
    cyc(1'b0, 1'b1, 1'b1, 16'($urandom), 16'($urandom));
    idle(CPS + 4);

    // Reset mid-stream with five pairs queued.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 16'($urandom), 16'($urandom));
    idle(40);
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
    idle(CPS + 4);

    // Randomized traffic: bursty producer, occasional pauses and resets.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 2999) == 0, $urandom_range(0, 49) != 0,
          $urandom_range(0, 179) == 0, 16'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
